// File: rtl/quad_step_decoder_if.sv
// Signal bundle between the quadrature front end and its environment.
// Strobe semantics: step/err are single-cycle pulses with no back-pressure; dir is valid whenever step is high.
interface quad_step_decoder_if #(
    parameter int ERRW = 8
);
    logic            a_in;
    logic            b_in;
    logic            clr_err;
    logic            dir;
    logic            step;
    logic            err;
    logic [ERRW-1:0] err_cnt;
    logic            armed;

    modport master (
        output a_in, b_in, clr_err,
        input  dir, step, err, err_cnt, armed
    );

    modport slave (
        input  a_in, b_in, clr_err,
        output dir, step, err, err_cnt, armed
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and glitch-filters A/B, decodes Gray steps into
// a one-cycle count strobe plus direction, and flags/counts illegal double transitions.
module quad_step_decoder #(
    parameter int FILT = 4,
    parameter int ERRW = 8
) (
    input  logic               clk,
    input  logic               rst,
    quad_step_decoder_if.slave bus
);
    localparam logic [7:0]      CNT_MAX = 8'(FILT - 1);
    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};

    typedef enum logic {
        ST_UNARMED = 1'b0,
        ST_ARMED   = 1'b1
    } state_t;

    state_t          state;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      cand;
    logic [1:0]      filt;
    logic [7:0]      cnt;
    logic            dir_q;
    logic            step_q;
    logic            err_q;
    logic [ERRW-1:0] err_cnt_q;

    logic commit;
    logic fwd;
    logic rev;
    logic dbl;

    // cnt at saturation means the candidate survived FILT consecutive samples.
    assign commit = (cnt == CNT_MAX) && ((cand != filt) || (state == ST_UNARMED));

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        dbl = 1'b0;
        case ({filt, cand})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: dbl = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_UNARMED;
            sync1     <= 2'b00;
            sync2     <= 2'b00;
            cand      <= 2'b00;
            filt      <= 2'b00;
            cnt       <= 8'd0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sync1 <= {bus.a_in, bus.b_in};
            sync2 <= sync1;

            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= 8'd0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 8'd1;
            end

            step_q <= 1'b0;
            err_q  <= 1'b0;
            if (commit) begin
                filt <= cand;
                // The first accepted value only establishes the reference phase.
                if (state == ST_UNARMED) begin
                    state <= ST_ARMED;
                end else if (fwd) begin
                    step_q <= 1'b1;
                    dir_q  <= 1'b1;
                end else if (rev) begin
                    step_q <= 1'b1;
                    dir_q  <= 1'b0;
                end else if (dbl) begin
                    err_q <= 1'b1;
                end
            end

            if (bus.clr_err) begin
                err_cnt_q <= '0;
            end else if (commit && (state == ST_ARMED) && dbl && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.dir     = dir_q;
    assign bus.step    = step_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.armed   = (state == ST_ARMED);
endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random phase activity, all
// compared each cycle against a sliding-window reference model.
module tb_quad_step_decoder;
    localparam int FILT = 4;
    localparam int ERRW = 2;
    localparam int ERR_SAT = (1 << ERRW) - 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_step_decoder_if #(.ERRW(ERRW)) bus ();

    quad_step_decoder #(.FILT(FILT), .ERRW(ERRW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int steps_seen = 0;
    int errs_seen  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // reference model: phase position on the Gray cycle, and a window of the last FILT samples
    logic [1:0] exp_q[$];
    logic [1:0] win_q[$];
    logic [1:0] filt_m;
    bit         armed_m;
    bit         dir_m;
    bit         step_m;
    bit         err_m;
    int         errcnt_m;
    bit         pend_commit;
    logic [1:0] pend_val;

    function automatic int gray_pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        exp_q = {};
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        win_q = {};
        win_q.push_back(2'b00);
        filt_m = 2'b00;
        armed_m = 1'b0;
        dir_m = 1'b1;
        step_m = 1'b0;
        err_m = 1'b0;
        errcnt_m = 0;
        pend_commit = 1'b0;
        pend_val = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] cur_in, input bit clr);
        int d;
        bit incr;
        bit same;
        logic [1:0] s;
        step_m = 1'b0;
        err_m = 1'b0;
        incr = 1'b0;
        if (pend_commit) begin
            if (!armed_m) begin
                armed_m = 1'b1;
            end else begin
                d = (gray_pos(pend_val) - gray_pos(filt_m) + 4) % 4;
                if (d == 1) begin step_m = 1'b1; dir_m = 1'b1; end
                else if (d == 3) begin step_m = 1'b1; dir_m = 1'b0; end
                else if (d == 2) begin err_m = 1'b1; incr = 1'b1; end
            end
            filt_m = pend_val;
        end
        if (clr) errcnt_m = 0;
        else if (incr && errcnt_m < ERR_SAT) errcnt_m++;

        s = exp_q.pop_front();
        exp_q.push_back(cur_in);
        win_q.push_back(s);
        if (win_q.size() > FILT) void'(win_q.pop_front());

        same = (win_q.size() == FILT);
        foreach (win_q[i]) if (win_q[i] != win_q[0]) same = 1'b0;
        pend_commit = same && ((win_q[0] != filt_m) || !armed_m);
        pend_val = win_q[0];
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_step"}, bus.step, step_m);
        check_eq({tag, "_err"}, bus.err, err_m);
        check_eq({tag, "_dir"}, bus.dir, dir_m);
        check_eq({tag, "_err_cnt"}, bus.err_cnt, errcnt_m);
        check_eq({tag, "_armed"}, bus.armed, armed_m);
        check_eq({tag, "_step_err_excl"}, bus.step & bus.err, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_step"}, bus.step, 1'b0);
        check_eq({tag, "_err"}, bus.err, 1'b0);
        check_eq({tag, "_dir"}, bus.dir, 1'b1);
        check_eq({tag, "_err_cnt"}, bus.err_cnt, 0);
        check_eq({tag, "_armed"}, bus.armed, 1'b0);
    endtask

    // driver tasks
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge({bus.a_in, bus.b_in}, bus.clr_err);
        #1;
        check_outputs(tag);
        if (bus.step) steps_seen++;
        if (bus.err) errs_seen++;
    endtask

    // Apply a phase value for `hold` cycles; report the edge count until step (0 = none).
    task automatic seg(input logic [1:0] v, input int hold, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        {bus.a_in, bus.b_in} = v;
        for (int i = 1; i <= hold; i++) begin
            tick(tag);
            if (bus.step && lat == 0) lat = i;
        end
        if (exp_lat >= 0) check_eq({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        int s0;
        int e0;
        rst = 1'b1;
        bus.a_in = 1'b0;
        bus.b_in = 1'b0;
        bus.clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // silent arming at 00
        seg(2'b00, 20, 0, "arm");
        check_eq("arm_armed", bus.armed, 1'b1);
        check_eq("arm_errs", errs_seen, 0);

        // forward sequence, 3 + FILT edges per step
        s0 = steps_seen;
        seg(2'b01, 10, 3 + FILT, "fwd1");
        seg(2'b11, 10, 3 + FILT, "fwd2");
        seg(2'b10, 10, 3 + FILT, "fwd3");
        seg(2'b00, 10, 3 + FILT, "fwd4");
        check_eq("fwd_steps", steps_seen - s0, 4);
        check_eq("fwd_dir", bus.dir, 1'b1);

        // reverse sequence
        s0 = steps_seen;
        seg(2'b10, 10, 3 + FILT, "rev1");
        seg(2'b11, 10, 3 + FILT, "rev2");
        seg(2'b01, 10, 3 + FILT, "rev3");
        seg(2'b00, 10, 3 + FILT, "rev4");
        check_eq("rev_steps", steps_seen - s0, 4);
        check_eq("rev_dir_held", bus.dir, 1'b0);

        // glitch shorter than FILT is rejected; FILT-long pulse gives a step out and back
        s0 = steps_seen;
        e0 = errs_seen;
        seg(2'b10, FILT - 1, -1, "short_pulse");
        seg(2'b00, 12, 0, "short_ret");
        check_eq("short_steps", steps_seen - s0, 0);
        seg(2'b10, FILT, -1, "long_pulse");
        seg(2'b00, 12, -1, "long_ret");
        check_eq("long_steps", steps_seen - s0, 2);
        check_eq("pulse_errs", errs_seen - e0, 0);

        // double transitions with a saturating counter
        s0 = steps_seen;
        e0 = errs_seen;
        seg(2'b11, 10, 0, "dbl1");
        seg(2'b00, 10, 0, "dbl2");
        seg(2'b11, 10, 0, "dbl3");
        seg(2'b00, 10, 0, "dbl4");
        seg(2'b11, 10, 0, "dbl5");
        check_eq("dbl_errs", errs_seen - e0, 5);
        check_eq("dbl_sat", bus.err_cnt, ERR_SAT);
        check_eq("dbl_steps", steps_seen - s0, 0);

        // clear coinciding with a 6th error
        {bus.a_in, bus.b_in} = 2'b00;
        repeat (2 + FILT) tick("clr_wait");
        bus.clr_err = 1'b1;
        tick("clr_hit");
        check_eq("clr_err_pulse", bus.err, 1'b1);
        check_eq("clr_err_cnt", bus.err_cnt, 0);
        bus.clr_err = 1'b0;
        repeat (5) tick("clr_after");

        // leave err_cnt and dir non-default before the mid-filter reset
        seg(2'b11, 10, -1, "pre_rst_err");
        seg(2'b01, 10, 3 + FILT, "pre_rst_rev1");
        seg(2'b00, 10, 3 + FILT, "pre_rst_rev2");
        check_eq("pre_rst_dir", bus.dir, 1'b0);

        // reset while the candidate 01 is part-way through the filter
        {bus.a_in, bus.b_in} = 2'b01;
        repeat (5) tick("mid_filter");
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        rst = 1'b0;
        model_reset();
        seg(2'b01, 20, 0, "rearm");
        check_eq("rearm_armed", bus.armed, 1'b1);

        // random phase activity with occasional clears
        for (int n = 0; n < 300; n++) begin
            int hold;
            {bus.a_in, bus.b_in} = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold; k++) begin
                bus.clr_err = ($urandom_range(0, 15) == 0);
                tick("rand");
            end
        end
        bus.clr_err = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
